chunked_adder_sequencer: RTL and testbench

- Multi-cycle wide adder that time-multiplexes a single 8-bit adder slice (sum = x + y + ci) across WIDTH/8 chunks, LSB chunk first, with a ripple carry register between cycles.
- Sits between operand producers and consumers in the approximate-arithmetic datapath.
- Trades latency for area versus a flat WIDTH-bit adder.
- Valid/ready handshakes on both input and output.

---
 rtl/chunked_adder_sequencer.sv | 85 ++++++++
 tb/tb_chunked_adder_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/chunked_adder_sequencer.sv
// chunked_adder_sequencer: WIDTH-bit adder run as CHUNKS passes of one 8-bit slice, LSB chunk first
//   clk, rst (async, active-high)
//   in_valid/in_ready, a, b, cin : operand handshake, captured on accept
//   out_valid/out_ready, sum, cout : result handshake, held stable until consumed
//   busy : high while an operation is in RUN or DONE
//   APPROX_LSB_CHUNK_EN : adds input approx; chunk 0 becomes a|b with no carry into chunk 1
module chunked_adder_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef APPROX_LSB_CHUNK_EN
  ,
  input  logic             approx
`endif
);
  localparam int CHUNKS = WIDTH / 8;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [7:0]       x, y, s;
  logic [8:0]       full;
  logic             co;
  logic             lsb_approx;
  assign x    = a_q[{idx, 3'b000} +: 8];
  assign y    = b_q[{idx, 3'b000} +: 8];
  assign full = {1'b0, x} + {1'b0, y} + {8'd0, carry};
`ifdef APPROX_LSB_CHUNK_EN
  logic approx_q;
  assign lsb_approx = approx_q && (idx == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) approx_q <= 1'b0;
    else if (state == IDLE && in_valid) approx_q <= approx;
`else
  assign lsb_approx = 1'b0;
`endif
  // approximate chunk 0 ignores the incoming carry and never produces one
  assign s  = lsb_approx ? (x | y) : full[7:0];
  assign co = lsb_approx ? 1'b0 : full[8];
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        carry <= cin;
        idx   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      sum[{idx, 3'b000} +: 8] <= s;
      carry <= co;
      if (idx == LAST) begin
        cout  <= co;
        state <= DONE;
      end else idx <= idx + 1'b1;
    end else if (out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// tb_chunked_adder_sequencer: directed self-checking bench for chunked_adder_sequencer
module tb_chunked_adder_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [31:0] a, b, sum;
`ifdef APPROX_LSB_CHUNK_EN
  logic        approx;
`endif
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  chunked_adder_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef APPROX_LSB_CHUNK_EN
    , .approx(approx)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_add(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic ap, input logic [31:0] es,
                        input logic ec, input int hold);
    int n;
    a = av;
    b = bv;
    cin = ci;
`ifdef APPROX_LSB_CHUNK_EN
    approx = ap;
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, " busy"}, {in_ready, busy}, 2'b01);
    n = 0;
    while (!out_valid && n < 20) begin
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom);
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1 check({tag, " hold"}, {out_valid, in_ready, busy, cout, sum}, {3'b101, ec, es});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " release"}, {out_valid, in_ready, busy}, 3'b010);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef APPROX_LSB_CHUNK_EN
    approx = 1'b0;
`endif
    #1 check("reset", {in_ready, out_valid, busy, cout, sum}, {3'b100, 1'b0, 32'h0});
    #11 rst = 1'b0;
    @(posedge clk);
    #1;
    do_add("basic", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 0);
    do_add("ovf", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 0);
    do_add("cin", 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 0);
    do_add("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 0);
    do_add("chunkcarry", 32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 0);
    do_add("backpressure", 32'h80000001, 32'h80000002, 1'b0, 1'b0, 32'h00000003, 1'b1, 10);
    a = 32'hDEADBEEF;
    b = 32'h11111111;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst", {in_ready, out_valid, busy, cout, sum}, {3'b100, 1'b0, 32'h0});
    #3 rst = 1'b0;
    @(posedge clk);
    #1 check("postrst idle", {in_ready, busy}, 2'b10);
    do_add("afterrst", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 0);
    do_add("churn", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 0);
`ifdef APPROX_LSB_CHUNK_EN
    do_add("approx1", 32'h000001F0, 32'h000000F0, 1'b0, 1'b1, 32'h000001F0, 1'b0, 0);
    do_add("approx1cin", 32'h000001F0, 32'h000000F0, 1'b1, 1'b1, 32'h000001F0, 1'b0, 0);
    do_add("approx0", 32'h000001F0, 32'h000000F0, 1'b0, 1'b0, 32'h000002E0, 1'b0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
